// File: rtl/channel_reduce_param.sv
// Streaming reducer: pops COUNT words, folds them with OP, then pushes the result.
// Optional CHANNEL_REDUCE_SATURATE_EN: saturating add plus a sticky sat output.
module channel_reduce_param #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned COUNT  = 4,
    parameter int unsigned OP     = 0,
    parameter int unsigned REPEAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] in_in_data,
    output logic             in_read_valid,
    output logic             in_rst,
    output logic             in_write_valid,
    input  logic [WIDTH-1:0] in_out_data,
    input  logic             in_read_ready,
    input  logic             in_write_ready,
    output logic [WIDTH-1:0] out_in_data,
    output logic             out_read_valid,
    output logic             out_rst,
    output logic             out_write_valid,
    input  logic [WIDTH-1:0] out_out_data,
    input  logic             out_read_ready,
    input  logic             out_write_ready,
    output logic             valid,
    output logic [15:0]      reductions
`ifdef CHANNEL_REDUCE_SATURATE_EN
    ,
    output logic             sat
`endif
);

    localparam int unsigned CW = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
    localparam logic [WIDTH-1:0] IDENT = (OP == 2) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_WAIT_IN  = 3'd1;
    localparam logic [2:0] S_POP      = 3'd2;
    localparam logic [2:0] S_ACC      = 3'd3;
    localparam logic [2:0] S_WAIT_OUT = 3'd4;
    localparam logic [2:0] S_PUSH     = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      red_q, red_d;
    logic [WIDTH-1:0] sum_w;
    logic             unused_inputs;

    assign sum_w         = acc_q + in_out_data;
    assign unused_inputs = ^{in_write_ready, out_out_data, out_read_ready};

`ifdef CHANNEL_REDUCE_SATURATE_EN
    logic sat_q, sat_d;
    assign sat = sat_q;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        red_d   = red_q;
`ifdef CHANNEL_REDUCE_SATURATE_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            S_INIT: begin
                acc_d   = IDENT;
                cnt_d   = '0;
`ifdef CHANNEL_REDUCE_SATURATE_EN
                sat_d   = 1'b0;
`endif
                state_d = S_WAIT_IN;
            end
            S_WAIT_IN: if (in_read_ready) state_d = S_POP;
            S_POP:     state_d = S_ACC;
            S_ACC: begin
                if (OP == 1) begin
                    if (in_out_data > acc_q) acc_d = in_out_data;
                end else if (OP == 2) begin
                    if (in_out_data < acc_q) acc_d = in_out_data;
                end else if (OP == 3) begin
                    acc_d = acc_q ^ in_out_data;
                end else begin
`ifdef CHANNEL_REDUCE_SATURATE_EN
                    // A wrapped sum is smaller than either operand.
                    if (sum_w < acc_q) begin
                        acc_d = {WIDTH{1'b1}};
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum_w;
                    end
`else
                    acc_d = sum_w;
`endif
                end
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST) ? S_WAIT_OUT : S_WAIT_IN;
            end
            S_WAIT_OUT: if (out_write_ready) state_d = S_PUSH;
            S_PUSH: begin
                red_d   = red_q + 16'd1;
                state_d = S_DONE;
            end
            S_DONE:  if (REPEAT != 0) state_d = S_INIT;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            acc_q   <= '0;
            cnt_q   <= '0;
            red_q   <= '0;
`ifdef CHANNEL_REDUCE_SATURATE_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            red_q   <= red_d;
`ifdef CHANNEL_REDUCE_SATURATE_EN
            sat_q   <= sat_d;
`endif
        end
    end

    // Strobes are masked by rst so nothing is issued in a reset cycle.
    assign in_read_valid   = (state_q == S_POP) && !rst;
    assign out_write_valid = (state_q == S_PUSH) && !rst;
    assign valid           = (state_q == S_DONE) && !rst;
    assign out_in_data     = acc_q;
    assign reductions      = red_q;
    assign in_in_data      = '0;
    assign in_rst          = 1'b0;
    assign in_write_valid  = 1'b0;
    assign out_read_valid  = 1'b0;
    assign out_rst         = 1'b0;

endmodule

// File: tb/tb_channel_reduce_param.sv
// Scoreboard bench for channel_reduce_param: six instances covering operators, widths,
// backpressure, repeat mode and mid-batch reset.
module tb_channel_reduce_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        total++;
        bad++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    // ---------------- dut0: default parameters ----------------
    logic rst0 = 1'b1, rdy0_in = 1'b1, rdy0_out = 1'b1, rr0 = 1'b0;
    logic [31:0] d0 = '0, od0, tie_d0;
    logic pop0, push0, v0;
    logic [3:0] tie_b0;
    logic [15:0] red0;
    logic [31:0] q0[$];
    exp_t e0[$];
    int pops0 = 0, pushes0 = 0, cyc0 = 0;

    channel_reduce_param u_dut0 (
        .clk(clk), .rst(rst0), .in_in_data(tie_d0), .in_read_valid(pop0),
        .in_rst(tie_b0[0]), .in_write_valid(tie_b0[1]), .in_out_data(d0),
        .in_read_ready(rr0), .in_write_ready(1'b0), .out_in_data(od0),
        .out_read_valid(tie_b0[2]), .out_rst(tie_b0[3]), .out_write_valid(push0),
        .out_out_data(32'd0), .out_read_ready(1'b0), .out_write_ready(rdy0_out),
        .valid(v0), .reductions(red0)
`ifdef CHANNEL_REDUCE_SATURATE_EN
        , .sat()
`endif
    );

    always @(posedge clk) if (pop0) d0 <= q0.pop_front();
    always @(negedge clk) rr0 <= rdy0_in && (q0.size() != 0);
    always @(posedge clk) begin
        cyc0    <= rst0 ? 0 : cyc0 + 1;
        pops0   <= rst0 ? 0 : pops0 + (pop0 ? 1 : 0);
        pushes0 <= rst0 ? 0 : pushes0 + (push0 ? 1 : 0);
    end
    always @(negedge clk) if (push0) begin
        if (e0.size() == 0) fail_msg("dut0 unexpected push");
        else begin
            exp_t e;
            e = e0.pop_front();
            check("dut0 push data", od0, e.data);
            if (e.cyc >= 0) check("dut0 push cycle", cyc0, e.cyc);
        end
    end

    // ---------------- dut8: WIDTH=8 COUNT=2 add ----------------
    logic rst_a = 1'b1, rr8 = 1'b0;
    logic [7:0] d8 = '0, od8, tie_d8;
    logic pop8, push8, v8;
    logic [3:0] tie_b8;
    logic [15:0] red8;
    logic [7:0] q8[$];
    logic [7:0] e8[$];
`ifdef CHANNEL_REDUCE_SATURATE_EN
    logic sat8, satmax;
`endif

    channel_reduce_param #(.WIDTH(8), .COUNT(2), .OP(0), .REPEAT(0)) u_dut8 (
        .clk(clk), .rst(rst_a), .in_in_data(tie_d8), .in_read_valid(pop8),
        .in_rst(tie_b8[0]), .in_write_valid(tie_b8[1]), .in_out_data(d8),
        .in_read_ready(rr8), .in_write_ready(1'b0), .out_in_data(od8),
        .out_read_valid(tie_b8[2]), .out_rst(tie_b8[3]), .out_write_valid(push8),
        .out_out_data(8'd0), .out_read_ready(1'b0), .out_write_ready(1'b1),
        .valid(v8), .reductions(red8)
`ifdef CHANNEL_REDUCE_SATURATE_EN
        , .sat(sat8)
`endif
    );

    always @(posedge clk) if (pop8) d8 <= q8.pop_front();
    always @(negedge clk) rr8 <= (q8.size() != 0);
    always @(negedge clk) if (push8) begin
        if (e8.size() == 0) fail_msg("dut8 unexpected push");
        else check("dut8 push data", od8, e8.pop_front());
    end

    // ---------------- operator instances: max / min / xor share one source ----------------
    logic rrop = 1'b0;
    logic [31:0] dop = '0, odmax, odmin, odxor, tie_dmax, tie_dmin, tie_dxor;
    logic popmax, popmin, popxor, pushmax, pushmin, pushxor, vmax, vmin, vxor;
    logic [3:0] tie_bmax, tie_bmin, tie_bxor;
    logic [15:0] redmax, redmin, redxor;
    logic [31:0] qop[$];
    logic [31:0] emax[$], emin[$], exor[$];

    channel_reduce_param #(.OP(1)) u_max (
        .clk(clk), .rst(rst_a), .in_in_data(tie_dmax), .in_read_valid(popmax),
        .in_rst(tie_bmax[0]), .in_write_valid(tie_bmax[1]), .in_out_data(dop),
        .in_read_ready(rrop), .in_write_ready(1'b0), .out_in_data(odmax),
        .out_read_valid(tie_bmax[2]), .out_rst(tie_bmax[3]), .out_write_valid(pushmax),
        .out_out_data(32'd0), .out_read_ready(1'b0), .out_write_ready(1'b1),
        .valid(vmax), .reductions(redmax)
`ifdef CHANNEL_REDUCE_SATURATE_EN
        , .sat(satmax)
`endif
    );

    channel_reduce_param #(.OP(2)) u_min (
        .clk(clk), .rst(rst_a), .in_in_data(tie_dmin), .in_read_valid(popmin),
        .in_rst(tie_bmin[0]), .in_write_valid(tie_bmin[1]), .in_out_data(dop),
        .in_read_ready(rrop), .in_write_ready(1'b0), .out_in_data(odmin),
        .out_read_valid(tie_bmin[2]), .out_rst(tie_bmin[3]), .out_write_valid(pushmin),
        .out_out_data(32'd0), .out_read_ready(1'b0), .out_write_ready(1'b1),
        .valid(vmin), .reductions(redmin)
`ifdef CHANNEL_REDUCE_SATURATE_EN
        , .sat()
`endif
    );

    channel_reduce_param #(.OP(3)) u_xor (
        .clk(clk), .rst(rst_a), .in_in_data(tie_dxor), .in_read_valid(popxor),
        .in_rst(tie_bxor[0]), .in_write_valid(tie_bxor[1]), .in_out_data(dop),
        .in_read_ready(rrop), .in_write_ready(1'b0), .out_in_data(odxor),
        .out_read_valid(tie_bxor[2]), .out_rst(tie_bxor[3]), .out_write_valid(pushxor),
        .out_out_data(32'd0), .out_read_ready(1'b0), .out_write_ready(1'b1),
        .valid(vxor), .reductions(redxor)
`ifdef CHANNEL_REDUCE_SATURATE_EN
        , .sat()
`endif
    );

    always @(posedge clk) if (popmax) dop <= qop.pop_front();
    always @(negedge clk) rrop <= (qop.size() != 0);
    always @(negedge clk) begin
        if (popmin !== popmax) fail_msg("min pop timing differs from max");
        if (popxor !== popmax) fail_msg("xor pop timing differs from max");
        if (pushmax) begin
            if (emax.size() == 0) fail_msg("max unexpected push");
            else check("max push data", odmax, emax.pop_front());
        end
        if (pushmin) begin
            if (emin.size() == 0) fail_msg("min unexpected push");
            else check("min push data", odmin, emin.pop_front());
        end
        if (pushxor) begin
            if (exor.size() == 0) fail_msg("xor unexpected push");
            else check("xor push data", odxor, exor.pop_front());
        end
    end

    // ---------------- dutr: REPEAT=1 ----------------
    logic rst_r = 1'b1, rrr = 1'b0;
    logic [31:0] dr = '0, odr, tie_dr;
    logic popr, pushr, vr, vr_prev = 1'b0;
    logic [3:0] tie_br;
    logic [15:0] redr;
    logic [31:0] qr[$];
    logic [31:0] er[$];
    int popsr = 0, vcnt = 0, vdbl = 0;

    channel_reduce_param #(.REPEAT(1)) u_dutr (
        .clk(clk), .rst(rst_r), .in_in_data(tie_dr), .in_read_valid(popr),
        .in_rst(tie_br[0]), .in_write_valid(tie_br[1]), .in_out_data(dr),
        .in_read_ready(rrr), .in_write_ready(1'b0), .out_in_data(odr),
        .out_read_valid(tie_br[2]), .out_rst(tie_br[3]), .out_write_valid(pushr),
        .out_out_data(32'd0), .out_read_ready(1'b0), .out_write_ready(1'b1),
        .valid(vr), .reductions(redr)
`ifdef CHANNEL_REDUCE_SATURATE_EN
        , .sat()
`endif
    );

    always @(posedge clk) if (popr) dr <= qr.pop_front();
    always @(negedge clk) rrr <= (qr.size() != 0);
    always @(posedge clk) begin
        popsr   <= popsr + (popr ? 1 : 0);
        vcnt    <= vcnt + (vr ? 1 : 0);
        vdbl    <= vdbl + ((vr && vr_prev) ? 1 : 0);
        vr_prev <= vr;
    end
    always @(negedge clk) if (pushr) begin
        if (er.size() == 0) fail_msg("repeat unexpected push");
        else check("repeat push data", odr, er.pop_front());
    end

    // ---------------- stimulus ----------------
    initial begin
        int p;
        q0 = '{32'd1, 32'd2, 32'd3, 32'd4};
        e0.push_back('{32'd10, 14});
        q8 = '{8'd200, 8'd100};
`ifdef CHANNEL_REDUCE_SATURATE_EN
        e8.push_back(8'd255);
`else
        e8.push_back(8'd44);
`endif
        qop = '{32'd7, 32'd3, 32'd9, 32'd3};
        emax.push_back(32'd9);
        emin.push_back(32'd3);
        exor.push_back(32'd14);
        qr = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2};
        er.push_back(32'd4);
        er.push_back(32'd8);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset pop strobe", pop0, 0);
        check("reset push strobe", push0, 0);
        check("reset valid", v0, 0);
        check("reset reductions", red0, 0);
        check("reset out data", od0, 0);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst_a = 1'b0;
        rst_r = 1'b0;

        for (int k = 0; k < 100 && !v0; k++) @(negedge clk);
        check("dut0 valid rise", v0, 1);
        check("dut0 valid rise cycle", cyc0, 15);
        repeat (5) @(negedge clk);
        check("dut0 valid held", v0, 1);
        check("dut0 reductions", red0, 1);
        check("dut0 pop count", pops0, 4);
        check("dut0 push count", pushes0, 1);
        check("dut0 tied outputs", {tie_d0, tie_b0}, 0);
        check("dut8 valid", v8, 1);
        check("dut8 reductions", red8, 1);
        check("max reductions", redmax, 1);
        check("min valid", vmin, 1);
        check("xor reductions", redxor, 1);
`ifdef CHANNEL_REDUCE_SATURATE_EN
        check("dut8 sat", sat8, 1);
        check("max sat", satmax, 0);
`endif

        // Backpressure run on dut0.
        @(posedge clk);
        #1;
        rst0 = 1'b1;
        rdy0_out = 1'b0;
        q0 = '{32'd5, 32'd6, 32'd7, 32'd8};
        e0.push_back('{32'd26, -1});
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        for (int k = 0; k < 100 && pops0 < 2; k++) @(negedge clk);
        check("bp second pop reached", pops0, 2);
        rdy0_in = 1'b0;
        p = pops0;
        repeat (5) @(negedge clk);
        check("bp no pop in gap", pops0, p);
        rdy0_in = 1'b1;
        for (int k = 0; k < 100 && pops0 < 4; k++) @(negedge clk);
        check("bp all pops", pops0, 4);
        repeat (4) @(negedge clk);
        check("bp push held", pushes0, 0);
        check("bp valid held low", v0, 0);
        rdy0_out = 1'b1;
        for (int k = 0; k < 100 && !v0; k++) @(negedge clk);
        check("bp valid", v0, 1);
        check("bp push count", pushes0, 1);
        check("bp reductions", red0, 1);

        // Repeat mode, then mid-batch reset.
        for (int k = 0; k < 200 && redr < 2; k++) @(negedge clk);
        check("repeat reductions", redr, 2);
        check("repeat valid pulses", vcnt, 2);
        check("repeat valid one cycle", vdbl, 0);
        qr.push_back(32'd7);
        qr.push_back(32'd7);
        for (int k = 0; k < 100 && popsr < 10; k++) @(negedge clk);
        check("abort second pop reached", popsr, 10);
        @(posedge clk);
        #1;
        rst_r = 1'b1;
        @(negedge clk);
        check("abort reset pop strobe", popr, 0);
        check("abort reset reductions", redr, 2);
        @(posedge clk);
        #1;
        rst_r = 1'b0;
        check("abort reductions cleared", redr, 0);
        er.push_back(32'd20);
        qr = '{32'd5, 32'd5, 32'd5, 32'd5};
        for (int k = 0; k < 200 && redr < 1; k++) @(negedge clk);
        check("abort next reductions", redr, 1);
        repeat (3) @(negedge clk);
        check("repeat total valid pulses", vcnt, 3);
        check("repeat no double valid", vdbl, 0);

        check("dut0 exp left", e0.size(), 0);
        check("dut8 exp left", e8.size(), 0);
        check("op exp left", emax.size() + emin.size() + exor.size(), 0);
        check("repeat exp left", er.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/channel_reduce_param.md
Name: channel_reduce_param

Overview:
Parametrised streaming reduction engine with selectable operator. It pops COUNT words from an input FIFO channel, folds them into an accumulator using the operator, and pushes the result to an output FIFO channel. It can run one-shot (halts with valid high) or repeat batch after batch. It is the generalised successor of the fixed 4-element sum reducer and uses the same channel port bundle.

Parameters:
WIDTH, 32, data width of channels and accumulator.
COUNT, 4, elements per reduction; legal range 1..65535.
OP, 0, operator: 0 add, 1 unsigned max, 2 unsigned min, 3 xor.
REPEAT, 0, 0 = one-shot then halt; 1 = restart after each result.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
in_in_data  out  WIDTH  input-channel write data; tied 0.
in_read_valid  out  1  input-channel pop strobe.
in_rst  out  1  input-channel reset; tied 0.
in_write_valid  out  1  tied 0.
in_out_data  in  WIDTH  input-channel read data; valid the cycle after the pop.
in_read_ready  in  1  input channel non-empty.
in_write_ready  in  1  unused.
out_in_data  out  WIDTH  output-channel write data; continuously equals acc.
out_read_valid  out  1  tied 0.
out_rst  out  1  tied 0.
out_write_valid  out  1  output-channel push strobe.
out_out_data  in  WIDTH  unused.
out_read_ready  in  1  unused.
out_write_ready  in  1  output channel not full.
valid  out  1  result-done flag.
reductions  out  16  completed-result counter; wraps at 65535->0.

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high.
- Reset state: INIT; acc=0; cnt=0; reductions=0; every strobe output and valid are 0.
- Reset in any state, including mid-batch, discards the partial batch. No pop or push is issued in the reset cycle.
- Identity value: add 0; max 0; min all-ones; xor 0.
- FSM states:
  - INIT: acc<=identity; cnt<=0; go to WAIT_IN.
  - WAIT_IN: if in_read_ready, go to POP; otherwise stay. No strobe in this state.
  - POP: in_read_valid=1 for exactly this cycle; go to ACC.
  - ACC: acc<=op(acc,in_out_data); cnt<=cnt+1.
    - If cnt==COUNT-1, go to WAIT_OUT; otherwise go to WAIT_IN.
  - WAIT_OUT: if out_write_ready, go to PUSH; otherwise stay. acc is held.
  - PUSH: out_write_valid=1 for exactly this cycle; out_in_data=acc; reductions<=reductions+1; go to DONE.
  - DONE: valid=1.
    - REPEAT=0: stay in DONE forever; valid stays high.
    - REPEAT=1: valid is high for one cycle; go to INIT.
- Arithmetic rules:
  - add wraps modulo 2^WIDTH (see optional feature).
  - max and min are unsigned compares; on equal operands acc is unchanged.
  - xor is bitwise.
- cnt width is clog2(COUNT+1).
- Timing, with both channels always ready and cycle 0 the first cycle after rst falls:
  - ACC of element n (0-based) occurs at cycle 3n+3.
  - PUSH occurs at cycle 3*COUNT+2.
  - valid first rises at cycle 3*COUNT+3, i.e. 15 for COUNT=4.
- Backpressure: a low in_read_ready or out_write_ready only adds cycles in WAIT_IN or WAIT_OUT. It never causes a spurious strobe or any change to acc or cnt.
- in_read_ready dropping during POP or ACC has no effect; the pop has already been committed.
- COUNT=1: one pop, then the result equals op(identity,x).

Optional Feature:
CHANNEL_REDUCE_SATURATE_EN:
- Defined, with OP=0: add saturates at 2^WIDTH-1. A sticky output port `sat` (1 bit) is added; it is set on any clipped add and cleared in INIT and on reset.
- Defined, with OP!=0: `sat` stays 0.
- Undefined: add wraps and there is no `sat` port.

Test Plan:
- Default parameters, in_read_ready=1, out_write_ready=1, inputs 1,2,3,4 -> exactly 4 pops, one push with out_in_data=10, valid=1 from cycle 15 and held, reductions=1.
- WIDTH=8, COUNT=2, OP=0, inputs 200,100 -> result 44; with CHANNEL_REDUCE_SATURATE_EN -> result 255 and sat=1.
- COUNT=4, inputs 7,3,9,3: OP=1 -> 9; OP=2 -> 3; OP=3 -> 14.
- Hold in_read_ready low for 5 cycles after the second pop -> no pop during the gap, result unchanged. Then hold out_write_ready low for 4 cycles -> out_write_valid stays 0 until ready, then exactly one push.
- REPEAT=1, batches {1,1,1,1} then {2,2,2,2} -> pushes 4 then 8, valid pulses twice for one cycle each, reductions=2.
- Assert rst for 1 cycle after the second ACC, then feed 5,5,5,5 -> no push from the aborted batch, next result 20.
